// File: rtl/c2sif_responder.sv
// c2sif responder: 4-phase req/ack target that replays each packet as word beats on a valid/ready bus.
// Optional per-beat bus timeout enabled by defining C2SIF_RESP_TIMEOUT_EN.
module c2sif_responder #(
  parameter int DATA_SIZE = 8,
  parameter int TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   c2s_req,
  input  logic [31:0]            c2s_id,
  input  logic [31:0]            c2s_fn,
  input  logic [31:0]            c2s_addr,
  input  logic [32*DATA_SIZE-1:0] c2s_data,
  output logic [31:0]            c2s_ret,
  output logic                   c2s_ack,
  output logic                   bus_req,
  output logic                   bus_we,
  output logic [31:0]            bus_addr,
  output logic [31:0]            bus_wdata,
  input  logic                   bus_ack,
  input  logic [31:0]            bus_rdata
);

  localparam int IW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
  localparam logic [31:0] FN_WRITE1 = 32'd1;
  localparam logic [31:0] FN_READ1  = 32'd2;
  localparam logic [31:0] FN_WRITEN = 32'd3;

  typedef enum logic [1:0] {IDLE, EXEC, BUS, ACK} state_t;

  state_t          state_q, state_n;
  logic            sync1_q, req_s;
  logic [31:0]     fn_q, fn_n;
  logic [29:0]     addr_q, addr_n;
  logic [31:0]     data_q [DATA_SIZE];
  logic [31:0]     data_n [DATA_SIZE];
  logic [IW-1:0]   beat_q, beat_n, beat_inc;
  logic            ack_n, bus_req_n, bus_we_n;
  logic [31:0]     ret_n, bus_addr_n, bus_wdata_n;
  logic            last_beat, tmo_hit;
  logic            unused_bits;

  // id only identifies the packet to the initiator; addr[1:0] never reach the word bus
  assign unused_bits = ^{c2s_id, c2s_addr[1:0]};

  assign beat_inc  = beat_q + IW'(1);
  assign last_beat = (fn_q != FN_WRITEN) || (beat_q == IW'(DATA_SIZE - 1));

`ifdef C2SIF_RESP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_q, tmo_n;
  assign tmo_hit = !bus_ack && (tmo_q == TW'(TIMEOUT - 1));
`else
  localparam int unused_timeout = TIMEOUT;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: if (req_s) state_n = EXEC;
      EXEC: begin
        if (fn_q == FN_WRITE1 || fn_q == FN_READ1 || fn_q == FN_WRITEN) state_n = BUS;
        else state_n = ACK;
      end
      BUS:  if ((bus_ack && last_beat) || tmo_hit) state_n = ACK;
      ACK:  if (!req_s) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Next values for the registered outputs and latched packet; everything holds by default.
  always_comb begin
    fn_n        = fn_q;
    addr_n      = addr_q;
    data_n      = data_q;
    beat_n      = beat_q;
    ack_n       = c2s_ack;
    ret_n       = c2s_ret;
    bus_req_n   = bus_req;
    bus_we_n    = bus_we;
    bus_addr_n  = bus_addr;
    bus_wdata_n = bus_wdata;
`ifdef C2SIF_RESP_TIMEOUT_EN
    tmo_n       = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_s) begin
          fn_n   = c2s_fn;
          addr_n = c2s_addr[31:2];
          beat_n = '0;
          for (int i = 0; i < DATA_SIZE; i++) data_n[i] = c2s_data[32*i +: 32];
        end
      end
      EXEC: begin
        case (fn_q)
          FN_WRITEN:                   ret_n = 32'(DATA_SIZE);
          32'd0, FN_WRITE1, FN_READ1:  ret_n = 32'd0;
          default:                     ret_n = 32'hFFFF_FFFF;
        endcase
        if (fn_q == FN_WRITE1 || fn_q == FN_READ1 || fn_q == FN_WRITEN) begin
          bus_req_n   = 1'b1;
          bus_we_n    = (fn_q != FN_READ1);
          bus_addr_n  = {addr_q, 2'b00};
          bus_wdata_n = data_q[0];
`ifdef C2SIF_RESP_TIMEOUT_EN
          tmo_n       = '0;
`endif
        end else begin
          ack_n = 1'b1;
        end
      end
      BUS: begin
        if (bus_ack) begin
          if (fn_q == FN_READ1) ret_n = bus_rdata;
          if (last_beat) begin
            bus_req_n = 1'b0;
            ack_n     = 1'b1;
          end else begin
            beat_n      = beat_inc;
            bus_addr_n  = {addr_q + 30'(beat_inc), 2'b00};
            bus_wdata_n = data_q[beat_inc];
`ifdef C2SIF_RESP_TIMEOUT_EN
            tmo_n       = '0;
`endif
          end
        end else if (tmo_hit) begin
          bus_req_n = 1'b0;
          ret_n     = 32'hFFFF_FFFE;
          ack_n     = 1'b1;
        end else begin
`ifdef C2SIF_RESP_TIMEOUT_EN
          tmo_n = tmo_q + TW'(1);
`endif
        end
      end
      ACK: if (!req_s) ack_n = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      req_s     <= 1'b0;
      fn_q      <= '0;
      addr_q    <= '0;
      beat_q    <= '0;
      c2s_ack   <= 1'b0;
      c2s_ret   <= '0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      for (int i = 0; i < DATA_SIZE; i++) data_q[i] <= '0;
`ifdef C2SIF_RESP_TIMEOUT_EN
      tmo_q     <= '0;
`endif
    end else begin
      sync1_q   <= c2s_req;
      req_s     <= sync1_q;
      fn_q      <= fn_n;
      addr_q    <= addr_n;
      beat_q    <= beat_n;
      c2s_ack   <= ack_n;
      c2s_ret   <= ret_n;
      bus_req   <= bus_req_n;
      bus_we    <= bus_we_n;
      bus_addr  <= bus_addr_n;
      bus_wdata <= bus_wdata_n;
      data_q    <= data_n;
`ifdef C2SIF_RESP_TIMEOUT_EN
      tmo_q     <= tmo_n;
`endif
    end
  end

endmodule
